pwm_multi: RTL

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with per-channel up/down buttons.
//
// Each channel owns a duty level 0..STEPS, stepped by debounced presses on
// its btn_up/btn_dn pair. All channels share one period counter. A channel's
// duty threshold is only reloaded at the period boundary, so a duty change
// never produces a truncated or stretched pulse.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   btn_up[i]     raw increment button for channel i
//   btn_dn[i]     raw decrement button for channel i
//   pwm_out[i]    registered PWM output of channel i
//   level         channel i duty level in bits [4i+3:4i]
//   segments      active-low 7-segment hex digit of channel i in bits
//                 [7i+6:7i] (bit 6 = a ... bit 0 = g)
//   period_start  one-cycle pulse while the period counter equals 0
module pwm_multi #(
  parameter int CHANNELS  = 2,
  parameter int PERIOD    = 2_000_000,
  parameter int STEPS     = 10,
  parameter int DB_CYCLES = 4,
  parameter int WRAP      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CHANNELS-1:0]     btn_up,
  input  logic [CHANNELS-1:0]     btn_dn,
  output logic [CHANNELS-1:0]     pwm_out,
  output logic [4*CHANNELS-1:0]   level,
  output logic [7*CHANNELS-1:0]   segments,
  output logic                    period_start
);

  localparam int CW  = $clog2(PERIOD);
  // Threshold can equal PERIOD, so it needs one bit more than the counter.
  localparam int TW  = CW + 1;
  // Product PERIOD*level with level <= 15 fits in CW+5 bits.
  localparam int PW  = CW + 5;
  // Up buttons occupy the low half, down buttons the high half.
  localparam int NIN = 2 * CHANNELS;
  localparam int DBW = $clog2(DB_CYCLES + 1);

  localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
  localparam logic [PW-1:0]  PERIOD_X = PW'(PERIOD);
  localparam logic [PW-1:0]  STEPS_X  = PW'(STEPS);
  localparam logic [3:0]     STEPS_L  = 4'(STEPS);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);

  logic [CW-1:0]  cnt;
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] db;
  logic [NIN-1:0] db_prev;
  logic [NIN-1:0] press;
  logic [DBW-1:0] db_cnt [NIN];
  logic [3:0]     lvl [CHANNELS];
  logic [TW-1:0]  thr [CHANNELS];
  logic [TW-1:0]  thr_calc [CHANNELS];

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Shared period counter. period_start is registered off the terminal
  // count so that it is high exactly while the counter holds 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= (cnt == CNT_LAST);
      cnt          <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign raw = {btn_dn, btn_up};

  // Two-flop synchroniser followed by a debouncer per button. The debounced
  // state only follows the synchronised input after it has disagreed for
  // DB_CYCLES consecutive cycles; a single agreeing cycle restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < NIN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Single-cycle pulse on each debounced rising edge.
  assign press = db & ~db_prev;

  // Level stepping. Simultaneous up and down on one channel cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lvl[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (press[c] && !press[CHANNELS + c]) begin
          if (lvl[c] == STEPS_L) begin
            lvl[c] <= (WRAP != 0) ? 4'd0 : STEPS_L;
          end else begin
            lvl[c] <= lvl[c] + 4'd1;
          end
        end else if (press[CHANNELS + c] && !press[c]) begin
          if (lvl[c] == 4'd0) begin
            lvl[c] <= (WRAP != 0) ? STEPS_L : 4'd0;
          end else begin
            lvl[c] <= lvl[c] - 4'd1;
          end
        end
      end
    end
  end

  // Candidate threshold floor(PERIOD*level/STEPS) for every channel.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      thr_calc[c] = TW'((PERIOD_X * PW'(lvl[c])) / STEPS_X);
    end
  end

  // The active threshold is reloaded on the last count so the new duty starts
  // cleanly at counter 0. The output compare on that same edge still uses the
  // old threshold, which finishes the current period unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        thr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cnt == CNT_LAST) begin
          thr[c] <= thr_calc[c];
        end
        pwm_out[c] <= ({1'b0, cnt} < thr[c]);
      end
    end
  end

  // Flatten levels and decode the display digits.
  always_comb begin
    level    = '0;
    segments = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      level[4*c +: 4]    = lvl[c];
      segments[7*c +: 7] = seg7(lvl[c]);
    end
  end

endmodule
